serv_issue_ctrl: RTL

//  Sequences one instruction at a time through the bit-serial core: fetches it over ibus,

---
 rtl/serv_issue_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/serv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// serv_issue_ctrl : one-instruction-at-a-time sequencer for the bit-serial core
//   (fetch, decode strobe, init/run passes, mem/shift waits).
//   Optional trap pass enabled by defining SERV_ISSUE_TRAP_EN.
// Revision: 1.0
// ============================================================================
module serv_issue_ctrl #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             i_rst_n,
  output logic             o_ibus_cyc,
  input  logic             i_ibus_ack,
  output logic             o_wb_en,
  input  logic             i_mem_op,
  input  logic             i_shift_op,
  input  logic             i_slt_op,
  input  logic             i_branch_op,
  input  logic             i_rd_op,
  input  logic             i_e_op,
  input  logic             i_sh_done,
  output logic             o_dbus_cyc,
  input  logic             i_dbus_ack,
  input  logic             i_mem_misalign,
  input  logic             i_jmp_misalign,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_cnt_en,
  output logic             o_cnt_done,
  output logic             o_init,
  output logic             o_run,
  output logic             o_rd_wen,
  output logic             o_pc_en,
  output logic             o_trap
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_INIT     = 3'd2,
    S_WAIT_MEM = 3'd3,
    S_WAIT_SH  = 3'd4,
    S_RUN      = 3'd5
`ifdef SERV_ISSUE_TRAP_EN
    , S_TRAP   = 3'd6
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ibus_cyc;
  logic             w_ibus_cyc_nxt;
  logic             r_dbus_cyc;
  logic             w_dbus_cyc_nxt;
  logic             w_two_stage;
  logic             w_cnt_last;
  logic             w_trap_pass;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_FETCH;
      r_cnt      <= '0;
      r_ibus_cyc <= 1'b0;
      r_dbus_cyc <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ibus_cyc <= w_ibus_cyc_nxt;
      r_dbus_cyc <= w_dbus_cyc_nxt;
    end
  end

  assign w_two_stage = i_mem_op | i_shift_op | i_slt_op | i_branch_op;
  assign w_cnt_last  = &r_cnt;

`ifdef SERV_ISSUE_TRAP_EN
  assign w_trap_pass = (r_state == S_TRAP);
`else
  logic w_unused_misalign;
  assign w_trap_pass       = 1'b0;
  assign w_unused_misalign = i_mem_misalign ^ i_jmp_misalign;
`endif

  assign o_ibus_cyc = r_ibus_cyc;
  assign o_dbus_cyc = r_dbus_cyc;
  assign o_cnt      = r_cnt;
  assign o_init     = (r_state == S_INIT);
  assign o_run      = (r_state == S_RUN);
  assign o_trap     = w_trap_pass;
  assign o_cnt_en   = o_init | o_run | o_trap;
  assign o_cnt_done = o_cnt_en & w_cnt_last;
  assign o_pc_en    = o_run | o_trap;
  // ecall only reaches RUN when the trap pass is compiled out; it must not write rd
  assign o_rd_wen   = o_run & i_rd_op & ~i_e_op;
  assign o_wb_en    = (r_state == S_FETCH) & r_ibus_cyc & i_ibus_ack;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = o_cnt_en ? (r_cnt + 1'b1) : r_cnt;
    w_ibus_cyc_nxt = r_ibus_cyc;
    w_dbus_cyc_nxt = r_dbus_cyc;
    case (r_state)
      S_FETCH: begin
        if (!r_ibus_cyc) begin
          w_ibus_cyc_nxt = 1'b1;
        end else if (i_ibus_ack) begin
          w_ibus_cyc_nxt = 1'b0;
          w_state_nxt    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_two_stage) begin
          w_state_nxt = S_INIT;
        end else begin
          w_state_nxt = S_RUN;
        end
`ifdef SERV_ISSUE_TRAP_EN
        if (i_e_op) begin
          w_state_nxt = S_TRAP;
        end
`endif
      end
      S_INIT: begin
        if (w_cnt_last) begin
          if (i_mem_op) begin
            w_state_nxt    = S_WAIT_MEM;
            w_dbus_cyc_nxt = 1'b1;
          end else if (i_shift_op) begin
            w_state_nxt = S_WAIT_SH;
          end else begin
            w_state_nxt = S_RUN;
          end
`ifdef SERV_ISSUE_TRAP_EN
          // a misaligned access or jump never issues its bus cycle
          if ((i_mem_op & i_mem_misalign) | (i_branch_op & i_jmp_misalign)) begin
            w_state_nxt    = S_TRAP;
            w_dbus_cyc_nxt = 1'b0;
          end
`endif
        end
      end
      S_WAIT_MEM: begin
        if (r_dbus_cyc & i_dbus_ack) begin
          w_dbus_cyc_nxt = 1'b0;
          w_state_nxt    = S_RUN;
        end
      end
      S_WAIT_SH: begin
        if (i_sh_done) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_cnt_last) begin
          w_state_nxt = S_FETCH;
        end
      end
`ifdef SERV_ISSUE_TRAP_EN
      S_TRAP: begin
        if (w_cnt_last) begin
          w_state_nxt = S_FETCH;
        end
      end
`endif
      default: begin
        w_state_nxt    = S_FETCH;
        w_ibus_cyc_nxt = 1'b0;
        w_dbus_cyc_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
